// File: rtl/datamem_stream_ctrl.sv
// rtl/datamem_stream_ctrl.sv - read sequencer streaming (base, length) words from the 512x16 data memory
// Credit-limited issue keeps memory reads plus buffered words within the 2-entry output queue.

module datamem_stream_fifo #(
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic [1:0]    o_cnt
);

  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_cnt   = r_cnt;

endmodule

module datamem_stream_ctrl #(
  parameter int AW    = 9,
  parameter int DW    = 16,
  parameter int LEN_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [AW-1:0]    i_cmd_base,
  input  logic [LEN_W-1:0] i_cmd_len,
  output logic [AW-1:0]    o_mem_raddr,
  input  logic [DW-1:0]    i_mem_dout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [DW-1:0]    o_out_data,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << AW);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_addr;
  logic [LEN_W-1:0] r_issue_rem;
  logic [LEN_W-1:0] r_deliv_rem;
  logic             r_inflight;

  logic [LEN_W-1:0] w_len;
  logic [1:0]       w_fifo_cnt;
  logic [2:0]       w_occ;
  logic             w_accept;
  logic             w_pop;
  logic             w_fire;
  logic             w_last_pop;

  assign w_len      = (i_cmd_len > MAX_LEN) ? MAX_LEN : i_cmd_len;
  assign w_accept   = i_cmd_valid && (r_state == S_IDLE);
  assign o_out_valid = (w_fifo_cnt != 2'd0);
  assign w_pop      = o_out_valid && i_out_ready;
  assign w_last_pop = w_pop && (r_deliv_rem == ONE);

  // Buffered words plus the read in flight, net of this cycle's pop, must stay below 2.
  assign w_occ  = {1'b0, w_fifo_cnt} + {2'b00, r_inflight};
  assign w_fire = (r_state == S_RUN) && (r_issue_rem != '0) &&
                  (w_occ < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (w_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_pop) begin
          w_next = S_DONE;
        end else if (w_fire && (r_issue_rem == ONE)) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_pop) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The address register drives the memory directly; it stops on the last fired address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_issue_rem <= '0;
      r_deliv_rem <= '0;
      r_inflight  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr      <= i_cmd_base;
        r_issue_rem <= w_len;
        r_deliv_rem <= w_len;
      end else begin
        if (w_fire) begin
          r_issue_rem <= r_issue_rem - ONE;
          if (r_issue_rem != ONE) begin
            r_addr <= r_addr + AW'(1);
          end
        end
        if (w_pop) begin
          r_deliv_rem <= r_deliv_rem - ONE;
        end
      end
      r_inflight <= w_fire;
    end
  end

  datamem_stream_fifo #(.DW(DW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_inflight),
    .i_wdata (i_mem_dout),
    .i_pop   (w_pop),
    .o_rdata (o_out_data),
    .o_cnt   (w_fifo_cnt)
  );

  assign o_mem_raddr = r_addr;
  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_out_last  = o_out_valid && (r_deliv_rem == ONE);

endmodule

// File: tb/tb_datamem_stream_ctrl.sv
// tb/tb_datamem_stream_ctrl.sv - directed vector bench for datamem_stream_ctrl
module tb_datamem_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_base = '0;
  logic [9:0]  cmd_len = '0;
  logic [8:0]  mem_raddr;
  logic [15:0] mem_dout = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] mem [512];

  int total = 0;
  int bad = 0;

  typedef struct {
    int base;
    int len;
    int mode;
    int exp_words;
    int exp_first;
    int exp_done;
  } vec_t;

  vec_t vecs [8];

  datamem_stream_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_base  (cmd_base),
    .i_cmd_len   (cmd_len),
    .o_mem_raddr (mem_raddr),
    .i_mem_dout  (mem_dout),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= mem[mem_raddr];

  initial begin
    #3000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask

  // mode 0: ready always high, 1: random, 2: high on odd cycles
  task automatic run_cmd(input int base, input int len, input int mode,
                         output int words, output int first_t, output int done_t);
    int          eff;
    int          held;
    logic [15:0] held_data;
    logic        r;
    eff = (len > 512) ? 512 : len;
    words = 0;
    first_t = -1;
    done_t = -1;
    held = 0;
    held_data = '0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_base = 9'(base);
    cmd_len = 10'(len);
    cmd_valid = 1'b1;
    out_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    if (eff > 0) chk("raddr_first", mem_raddr, base);
    for (int t = 0; t < 2000; t++) begin
      if (held != 0) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_data);
      end
      if (out_valid && first_t < 0) first_t = t;
      if (done) begin
        done_t = t;
        chk("no_valid_in_done", out_valid, 0);
        break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = ((t % 2) == 1);
      endcase
      out_ready = r;
      if (out_valid && r) begin
        chk("data", out_data, mem[(base + words) % 512]);
        chk("last", out_last, (words == eff - 1));
        words++;
        held = 0;
      end else begin
        held = out_valid ? 1 : 0;
        held_data = out_data;
      end
      step();
    end
    chk("done_seen", (done_t >= 0), 1);
    out_ready = 1'b0;
    step();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", cmd_ready, 1);
    chk("not_busy_after_done", busy, 0);
  endtask

  initial begin
    int w;
    int f;
    int d;
    int cnt;
    int rdy_t;
    int done_t;
    int done_n;

    vecs[0] = '{base: 0,   len: 8,    mode: 0, exp_words: 8,   exp_first: 2,  exp_done: 10};
    vecs[1] = '{base: 510, len: 4,    mode: 0, exp_words: 4,   exp_first: 2,  exp_done: 6};
    vecs[2] = '{base: 37,  len: 16,   mode: 1, exp_words: 16,  exp_first: 2,  exp_done: -1};
    vecs[3] = '{base: 5,   len: 0,    mode: 0, exp_words: 0,   exp_first: -1, exp_done: 0};
    vecs[4] = '{base: 300, len: 600,  mode: 0, exp_words: 512, exp_first: 2,  exp_done: 514};
    vecs[5] = '{base: 200, len: 1,    mode: 0, exp_words: 1,   exp_first: 2,  exp_done: 3};
    vecs[6] = '{base: 64,  len: 6,    mode: 2, exp_words: 6,   exp_first: 2,  exp_done: -1};
    vecs[7] = '{base: 1,   len: 1023, mode: 0, exp_words: 512, exp_first: 2,  exp_done: 514};

    for (int i = 0; i < 512; i++) mem[i] = 16'((i * 37) + 16'h1000);

    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].base, vecs[i].len, vecs[i].mode, w, f, d);
      chk($sformatf("vec%0d_words", i), w, vecs[i].exp_words);
      chk($sformatf("vec%0d_first_valid", i), f, vecs[i].exp_first);
      if (vecs[i].exp_done >= 0) chk($sformatf("vec%0d_done_cycle", i), d, vecs[i].exp_done);
    end

    // reset three words into a len=10 stream
    cmd_base = 9'd0;
    cmd_len = 10'd10;
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    cnt = 0;
    for (int t = 0; t < 20 && cnt < 3; t++) begin
      if (out_valid) cnt++;
      step();
    end
    chk("mid_pops", cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_raddr", mem_raddr, 0);
    out_ready = 1'b0;
    step();
    step();
    chk("mid_rst_hold_done", done, 0);
    rst_n = 1'b1;
    step();
    run_cmd(100, 2, 0, w, f, d);
    chk("post_rst_words", w, 2);
    chk("post_rst_first_valid", f, 2);
    chk("post_rst_done_cycle", d, 4);

    // cmd_valid held high through a len=4 command
    cmd_base = 9'd20;
    cmd_len = 10'd4;
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    step();
    cnt = 0;
    rdy_t = -1;
    done_t = -1;
    done_n = 0;
    for (int t = 0; t < 40; t++) begin
      if (cmd_ready && rdy_t < 0) rdy_t = t;
      if (done) begin
        done_n++;
        if (done_t < 0) done_t = t;
      end
      if (out_valid) begin
        chk("held_data", out_data, mem[20 + (cnt % 4)]);
        cnt++;
      end
      if (t == 8) begin
        cmd_valid = 1'b0;
        chk("held_second_busy", busy, 1);
        chk("held_second_raddr", mem_raddr, 20);
      end
      step();
    end
    chk("held_ready_cycle", rdy_t, 7);
    chk("held_done_cycle", done_t, 6);
    chk("held_done_pulses", done_n, 2);
    chk("held_words", cnt, 8);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
